// File: rtl/seg7_to_hex_decoder.sv
// seg7_to_hex_decoder: turns a sampled, active-low 7-segment pattern stream
// back into hex digits. A pattern is accepted once STABLE_CNT consecutive
// identical valid samples (same pattern and position) have been seen. Each
// accepted digit is written into a per-position shadow (digits) and offered
// on a one-entry valid/ready holding register.
//
// Ports
//   clk        - clock, all state changes on rising edge
//   rst_n      - synchronous active-low reset
//   seg_in     - segment pattern, bit0=a .. bit6=g, 0 = lit
//   seg_valid  - qualifies seg_in / digit_sel
//   digit_sel  - display position of the current sample
//   hex_out    - value of the held digit
//   hex_pos    - position of the held digit
//   hex_blank  - held digit was the all-off pattern
//   hex_err    - held digit was not in the decode table
//   hex_valid  - holding register full
//   hex_ready  - consumer takes the held digit when high with hex_valid
//   digits     - last accepted value per position, position n in [4n+3:4n]
//   overflow   - sticky, an accepted digit found the holding register busy
module seg7_to_hex_decoder #(
    parameter int unsigned STABLE_CNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic        seg_valid,
    input  logic [1:0]  digit_sel,
    output logic [3:0]  hex_out,
    output logic [1:0]  hex_pos,
    output logic        hex_blank,
    output logic        hex_err,
    output logic        hex_valid,
    input  logic        hex_ready,
    output logic [15:0] digits,
    output logic        overflow
);

    localparam logic [3:0] StableCnt = 4'(STABLE_CNT);

    typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cand_pat_q, cand_pat_d;
    logic [1:0]  cand_pos_q, cand_pos_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [3:0]  hex_out_q, hex_out_d;
    logic [1:0]  hex_pos_q, hex_pos_d;
    logic        hex_blank_q, hex_blank_d;
    logic        hex_err_q, hex_err_d;
    logic        hex_valid_q, hex_valid_d;
    logic [15:0] digits_q, digits_d;
    logic        overflow_q, overflow_d;

    logic        sample_eq;
    logic        reload;
    logic        accept;
    logic [3:0]  cnt_inc;
    logic [3:0]  dec_val;
    logic        dec_blank;
    logic        dec_err;

    // Segment pattern to hex value; anything outside the table is either the
    // blank pattern or an error, both reported with value 0.
    always_comb begin
        dec_val   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (seg_in)
            7'h40: dec_val = 4'h0;
            7'h79: dec_val = 4'h1;
            7'h24: dec_val = 4'h2;
            7'h30: dec_val = 4'h3;
            7'h19: dec_val = 4'h4;
            7'h12: dec_val = 4'h5;
            7'h02: dec_val = 4'h6;
            7'h78: dec_val = 4'h7;
            7'h00: dec_val = 4'h8;
            7'h10: dec_val = 4'h9;
            7'h08: dec_val = 4'hA;
            7'h03: dec_val = 4'hB;
            7'h46: dec_val = 4'hC;
            7'h21: dec_val = 4'hD;
            7'h06: dec_val = 4'hE;
            7'h0E: dec_val = 4'hF;
            7'h7F: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    assign sample_eq = (seg_in == cand_pat_q) && (digit_sel == cand_pos_q);
    assign cnt_inc   = cnt_q + 4'd1;

    // Stability tracker. Accepted data always comes from the current sample,
    // which equals the candidate whenever an accept happens on a match.
    always_comb begin
        state_d    = state_q;
        cand_pat_d = cand_pat_q;
        cand_pos_d = cand_pos_q;
        cnt_d      = cnt_q;
        reload     = 1'b0;
        accept     = 1'b0;
        if (seg_valid) begin
            unique case (state_q)
                StIdle: reload = 1'b1;
                StTrack: begin
                    if (sample_eq) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == StableCnt) begin
                            accept  = 1'b1;
                            state_d = StLocked;
                        end
                    end else begin
                        reload = 1'b1;
                    end
                end
                StLocked: begin
                    // One accept per stable run; repeats are ignored.
                    if (!sample_eq) begin
                        reload = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
            if (reload) begin
                cand_pat_d = seg_in;
                cand_pos_d = digit_sel;
                cnt_d      = 4'd1;
                if (StableCnt == 4'd1) begin
                    accept  = 1'b1;
                    state_d = StLocked;
                end else begin
                    state_d = StTrack;
                end
            end
        end
    end

    // Holding register and per-position shadow.
    always_comb begin
        hex_out_d   = hex_out_q;
        hex_pos_d   = hex_pos_q;
        hex_blank_d = hex_blank_q;
        hex_err_d   = hex_err_q;
        hex_valid_d = hex_valid_q;
        digits_d    = digits_q;
        overflow_d  = overflow_q;
        if (accept) begin
            digits_d[{digit_sel, 2'b00} +: 4] = dec_val;
            if (!hex_valid_q || hex_ready) begin
                hex_out_d   = dec_val;
                hex_pos_d   = digit_sel;
                hex_blank_d = dec_blank;
                hex_err_d   = dec_err;
                hex_valid_d = 1'b1;
            end else begin
                // Register busy and not being drained: drop the new digit.
                overflow_d = 1'b1;
            end
        end else if (hex_valid_q && hex_ready) begin
            hex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cand_pat_q  <= 7'h7F;
            cand_pos_q  <= 2'd0;
            cnt_q       <= 4'd0;
            hex_out_q   <= 4'h0;
            hex_pos_q   <= 2'd0;
            hex_blank_q <= 1'b0;
            hex_err_q   <= 1'b0;
            hex_valid_q <= 1'b0;
            digits_q    <= 16'h0000;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_pat_q  <= cand_pat_d;
            cand_pos_q  <= cand_pos_d;
            cnt_q       <= cnt_d;
            hex_out_q   <= hex_out_d;
            hex_pos_q   <= hex_pos_d;
            hex_blank_q <= hex_blank_d;
            hex_err_q   <= hex_err_d;
            hex_valid_q <= hex_valid_d;
            digits_q    <= digits_d;
            overflow_q  <= overflow_d;
        end
    end

    assign hex_out   = hex_out_q;
    assign hex_pos   = hex_pos_q;
    assign hex_blank = hex_blank_q;
    assign hex_err   = hex_err_q;
    assign hex_valid = hex_valid_q;
    assign digits    = digits_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seg7_to_hex_decoder.sv
// Bench for seg7_to_hex_decoder: directed scenarios followed by randomized
// sample runs, all compared each cycle against a run-length reference model.
module tb_seg7_to_hex_decoder;

    localparam int unsigned N = 3;
    localparam logic [6:0] TBL [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic        seg_valid;
    logic [1:0]  digit_sel;
    logic [3:0]  hex_out;
    logic [1:0]  hex_pos;
    logic        hex_blank;
    logic        hex_err;
    logic        hex_valid;
    logic        hex_ready;
    logic [15:0] digits;
    logic        overflow;

    always #5 clk = ~clk;

    seg7_to_hex_decoder #(.STABLE_CNT(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .digit_sel (digit_sel),
        .hex_out   (hex_out),
        .hex_pos   (hex_pos),
        .hex_blank (hex_blank),
        .hex_err   (hex_err),
        .hex_valid (hex_valid),
        .hex_ready (hex_ready),
        .digits    (digits),
        .overflow  (overflow)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a digit is accepted exactly when the current run of
    // identical valid samples reaches length N.
    int         m_run;
    logic [6:0] m_last_pat;
    logic [1:0] m_last_pos;
    logic [3:0] m_out;
    logic [1:0] m_pos;
    logic       m_blank, m_err, m_valid, m_ovf;
    logic [3:0] m_dig [4];

    task automatic m_decode(input logic [6:0] p, output logic [3:0] v, output logic b,
                            output logic e);
        v = 4'h0;
        b = (p == 7'h7F);
        e = !b;
        for (int i = 0; i < 16; i++) begin
            if (TBL[i] == p) begin
                v = 4'(i);
                e = 1'b0;
            end
        end
    endtask

    task automatic m_reset();
        m_run   = 0;
        m_out   = 4'h0;
        m_pos   = 2'd0;
        m_blank = 1'b0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    endtask

    task automatic m_step();
        logic       acc;
        logic [3:0] v;
        logic       b, e;
        acc = 1'b0;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (seg_valid) begin
            if (m_run > 0 && seg_in == m_last_pat && digit_sel == m_last_pos) begin
                m_run++;
            end else begin
                m_run      = 1;
                m_last_pat = seg_in;
                m_last_pos = digit_sel;
            end
            acc = (m_run == int'(N));
        end
        if (acc) begin
            m_decode(seg_in, v, b, e);
            m_dig[digit_sel] = v;
            if (!m_valid || hex_ready) begin
                m_out   = v;
                m_pos   = digit_sel;
                m_blank = b;
                m_err   = e;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && hex_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic cycle(input logic rn, input logic v, input logic [6:0] s,
                         input logic [1:0] p, input logic rdy);
        rst_n     = rn;
        seg_valid = v;
        seg_in    = s;
        digit_sel = p;
        hex_ready = rdy;
        @(posedge clk);
        m_step();
        #1;
        check_eq("hex_valid", 32'(hex_valid), 32'(m_valid));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("digits", 32'(digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        if (m_valid) begin
            check_eq("hex_out", 32'(hex_out), 32'(m_out));
            check_eq("hex_pos", 32'(hex_pos), 32'(m_pos));
            check_eq("hex_blank", 32'(hex_blank), 32'(m_blank));
            check_eq("hex_err", 32'(hex_err), 32'(m_err));
        end
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 7'h7F, 2'd0, 1'b0);
        cycle(1'b0, 1'b0, 7'h7F, 2'd0, 1'b0);
    endtask

    task automatic feed(input logic [6:0] s, input logic [1:0] p, input logic rdy, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, s, p, rdy);
    endtask

    initial begin
        logic [6:0]  r_pat;
        logic [1:0]  r_pos;
        int          hold;
        int unsigned r;

        m_last_pat = 7'h7F;
        m_last_pos = 2'd0;
        m_reset();

        // Reset state, all outputs including those not gated by valid.
        do_reset();
        check_eq("rst_out", 32'(hex_out), 32'h0);
        check_eq("rst_pos", 32'(hex_pos), 32'h0);
        check_eq("rst_blank", 32'(hex_blank), 32'h0);
        check_eq("rst_err", 32'(hex_err), 32'h0);

        // Stable '2' at position 1.
        feed(7'h24, 2'd1, 1'b1, 2);
        check_eq("r32_early", 32'(hex_valid), 32'h0);
        feed(7'h24, 2'd1, 1'b1, 1);
        check_eq("r32_valid", 32'(hex_valid), 32'h1);
        check_eq("r32_out", 32'(hex_out), 32'h2);
        check_eq("r32_pos", 32'(hex_pos), 32'h1);
        check_eq("r32_digits", 32'(digits), 32'h0020);
        feed(7'h24, 2'd1, 1'b1, 3);
        check_eq("r32_noreaccept", 32'(hex_valid), 32'h0);

        // Short run of '4' must not be emitted; '5' is.
        feed(7'h19, 2'd0, 1'b1, 2);
        feed(7'h12, 2'd0, 1'b1, 2);
        check_eq("r33_no4", 32'(hex_valid), 32'h0);
        feed(7'h12, 2'd0, 1'b1, 1);
        check_eq("r33_out", 32'(hex_out), 32'h5);
        check_eq("r33_digits", 32'(digits), 32'h0025);

        // Blank and error patterns.
        feed(7'h7F, 2'd2, 1'b1, 3);
        check_eq("r34_blank", 32'({hex_valid, hex_blank, hex_err, hex_out}), 32'h60);
        feed(7'h3F, 2'd2, 1'b1, 3);
        check_eq("r34_err", 32'({hex_valid, hex_blank, hex_err, hex_out}), 32'h50);

        // Overflow with consumer stalled.
        do_reset();
        feed(7'h40, 2'd0, 1'b0, 3);
        feed(7'h79, 2'd0, 1'b0, 3);
        check_eq("r35_out", 32'(hex_out), 32'h0);
        check_eq("r35_ovf", 32'(overflow), 32'h1);
        check_eq("r35_digit0", 32'(digits[3:0]), 32'h1);
        cycle(1'b1, 1'b0, 7'h79, 2'd0, 1'b1);
        check_eq("r35_drain", 32'(hex_valid), 32'h0);
        check_eq("r35_sticky", 32'(overflow), 32'h1);

        // Accept coinciding with a handshake.
        do_reset();
        feed(7'h40, 2'd3, 1'b0, 3);
        feed(7'h79, 2'd3, 1'b0, 2);
        feed(7'h79, 2'd3, 1'b1, 1);
        check_eq("r36_valid", 32'(hex_valid), 32'h1);
        check_eq("r36_out", 32'(hex_out), 32'h1);
        check_eq("r36_ovf", 32'(overflow), 32'h0);

        // Reset mid-run discards the candidate.
        do_reset();
        feed(7'h40, 2'd0, 1'b1, 2);
        cycle(1'b0, 1'b1, 7'h40, 2'd0, 1'b1);
        feed(7'h40, 2'd0, 1'b1, 1);
        check_eq("r37_valid", 32'(hex_valid), 32'h0);
        check_eq("r37_digits", 32'(digits), 32'h0);

        // Randomized runs.
        hold  = 0;
        r_pat = 7'h40;
        r_pos = 2'd0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                r = $urandom_range(0, 19);
                if (r < 16) r_pat = TBL[r];
                else if (r == 16) r_pat = 7'h7F;
                else if (r == 17) r_pat = 7'h3F;
                else r_pat = 7'($urandom);
                if ($urandom_range(0, 3) == 0) r_pos = 2'($urandom);
                hold = int'($urandom_range(1, 6));
            end
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 4) != 0), r_pat, r_pos,
                  1'($urandom));
            hold--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_to_hex_decoder.md
SEG7_TO_HEX_DECODER -- requirements
Module: seg7_to_hex_decoder

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 3: consecutive identical valid samples needed to accept a pattern (legal 1..15).
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port seg_in, input, 7: segment pattern, bit0=a..bit6=g, active-low (0 = segment lit).
REQ-005 SHALL have port seg_valid, input, 1: seg_in and digit_sel are sampled only when high.
REQ-006 SHALL have port digit_sel, input, 2: display position (0..3) of the current sample.
REQ-007 SHALL have port hex_out, output, 4: decoded value of the held digit.
REQ-008 SHALL have port hex_pos, output, 2: position of the held digit.
REQ-009 SHALL have port hex_blank, output, 1: held digit was all-off pattern 7'h7F.
REQ-010 SHALL have port hex_err, output, 1: held digit was a non-table, non-blank pattern.
REQ-011 SHALL have port hex_valid, output, 1: output holding register full.
REQ-012 SHALL have port hex_ready, input, 1: consumer accepts the held digit when high with hex_valid.
REQ-013 SHALL have port digits, output, 16: last accepted hex value per position, position n in bits [4n+3:4n].
REQ-014 SHALL have port overflow, output, 1: sticky; an accepted digit was dropped.

Function
REQ-015 Decode table (seg_in -> value) SHALL be: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F (hex).
REQ-016 7'h7F SHALL decode as blank (value 0, hex_blank=1); any other non-table pattern, including 7'h3F, SHALL decode as error (value 0, hex_err=1).
REQ-017 Stability FSM SHALL have states IDLE, TRACK, LOCKED, plus candidate {pattern, position} and a 4-bit match counter.
REQ-018 While seg_valid=0 the FSM, candidate and counter SHALL hold.
REQ-019 IDLE, valid sample: load candidate, count=1, go TRACK; if STABLE_CNT=1, accept immediately and go LOCKED.
REQ-020 TRACK, sample equal to candidate: count+1; when count reaches STABLE_CNT, accept and go LOCKED.
REQ-021 TRACK or LOCKED, sample differing in pattern or position: reload candidate, count=1, go TRACK (STABLE_CNT=1: accept, stay LOCKED).
REQ-022 LOCKED, equal sample: stay LOCKED, no further accept (one accept per stable run).
REQ-023 On accept, hex_out/hex_pos/hex_blank/hex_err and hex_valid SHALL update on the next rising edge (latency 1 cycle after the STABLE_CNT-th matching sample).
REQ-024 On accept, digits[pos] SHALL update on the same edge, blank/error digits included (value 0), regardless of output handshake.
REQ-025 hex_valid=1 and hex_ready=1 with no accept: hex_valid clears next edge.
REQ-026 Accept with hex_valid=1 and hex_ready=1 same cycle: register loads the new digit and hex_valid stays 1; overflow is unchanged.
REQ-027 Accept with hex_valid=1 and hex_ready=0: new digit dropped from the holding register, held digit unchanged, overflow set to 1.
REQ-028 overflow SHALL clear only on reset.
REQ-029 Held outputs SHALL remain stable while hex_valid=1 and hex_ready=0.

Reset
REQ-030 With rst_n=0 at a rising edge: FSM=IDLE, count=0, candidate=7'h7F/pos 0, hex_out=0, hex_pos=0, hex_blank=0, hex_err=0, hex_valid=0, digits=16'h0000, overflow=0.
REQ-031 Reset asserted mid-TRACK SHALL discard the candidate; no accept from pre-reset samples.

Verification
REQ-032 STABLE_CNT=3, seg_in=7'h24, pos 1, valid 3 cycles, hex_ready=1 -> one cycle after third sample: hex_valid=1, hex_out=2, hex_pos=1; digits=16'h0020; no second accept while held.
REQ-033 Sequence 7'h19,7'h19,7'h12,7'h12,7'h12 (pos 0) -> only 5 accepted, after the fifth sample; no 4 emitted.
REQ-034 seg_in=7'h7F then 7'h3F, each 3 cycles -> first: hex_blank=1, hex_out=0; second: hex_err=1, hex_out=0.
REQ-035 hex_ready=0, accept 7'h40 then 7'h79 -> hex_out stays 0, overflow=1, digits[3:0]=1; hex_ready=1 then clears hex_valid.
REQ-036 Accept coinciding with hex_ready=1 handshake -> new digit loaded, hex_valid continuous, overflow=0.
REQ-037 rst_n=0 after two matching samples, then release and one more match -> no accept; all outputs at reset values.
